// File: rtl/data_memory_sized.sv
// data_memory_sized: M-stage data memory with self-initialising sweep, byte/half/word access and registered response.
module data_memory_sized #(
  parameter int ADDR_BITS = 6,
  parameter int INIT_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t                 r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]   r_init_cnt;
  logic [31:0]            r_mem [DEPTH];
  logic                   w_accept, w_fault, w_store;
  logic [ADDR_BITS-1:0]   w_widx;
  logic [3:0]             w_be;
  logic [31:0]            w_wlane, w_word, w_load, w_init_val;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_INIT;
    else r_state <= w_state_nxt;
  always_comb w_state_nxt = (r_state == S_INIT && &r_init_cnt) ? S_RUN : r_state;
  always_comb begin
    req_ready = r_state == S_RUN;
    init_done = r_state == S_RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_init_cnt <= '0;
    else if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
  always_comb begin
    w_accept   = req_valid & req_ready;
    w_widx     = req_addr[ADDR_BITS+1:2];
    w_fault    = (req_size == 2'b11) | (|req_addr[31:ADDR_BITS+2]) |
                 (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
    w_store    = w_accept & req_write & ~w_fault;
    w_be       = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                 req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wlane    = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                 req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    w_init_val = INIT_MODE != 0 ? 32'(r_init_cnt) : '0;
    w_word     = r_mem[w_widx];
    w_byte     = w_word[{req_addr[1:0], 3'b000} +: 8];
    w_half     = req_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load     = req_size == 2'b00 ? {{24{~req_unsigned & w_byte[7]}}, w_byte} :
                 req_size == 2'b01 ? {{16{~req_unsigned & w_half[15]}}, w_half} : w_word;
  end
  // Memory contents are only defined by the INIT sweep, so this array has no reset.
  always_ff @(posedge clk)
    if (r_state == S_INIT) r_mem[r_init_cnt] <= w_init_val;
    else if (w_store)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wlane[8*b +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_accept;
      if (w_accept) begin
        rsp_fault <= w_fault;
        rsp_rdata <= (w_fault | req_write) ? '0 : w_load;
      end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: table-driven load/store/fault vectors plus hand sequences for INIT, back-to-back and reset.
module tb_data_memory_sized;
  logic        clk = 0, reset = 0, req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_fault, init_done;
  logic [31:0] rsp_rdata;
  int n_tests = 0, n_fail = 0;

  data_memory_sized #(.ADDR_BITS(6), .INIT_MODE(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wr;
    bit [1:0]    sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          fault;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit wr, input bit [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit fault,
                     input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.fault = fault; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic set_req(input bit wr, input bit [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Called at the negedge where reset is released; counts cycles until ready rises.
  task automatic run_init(input string name);
    int n = 0;
    bit spur = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
      spur |= rsp_valid;
    end
    req_valid = 0;
    check({name, " init cycles"}, n, 64);
    check({name, " init_done"}, {31'b0, init_done}, 1);
    check({name, " no rsp during init"}, {31'b0, spur}, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, " req_ready"}, {31'b0, req_ready}, 0);
    check({name, " init_done"}, {31'b0, init_done}, 0);
    check({name, " rsp_valid"}, {31'b0, rsp_valid}, 0);
    check({name, " rsp_fault"}, {31'b0, rsp_fault}, 0);
    check({name, " rsp_rdata"}, rsp_rdata, 0);
  endtask

  task automatic single(input string name, input bit wr, input bit [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit fault, input logic [31:0] rdata);
    set_req(wr, sz, uns, addr, wdata);
    @(negedge clk);
    req_valid = 0;
    check({name, " valid"}, {31'b0, rsp_valid}, 1);
    check({name, " fault"}, {31'b0, rsp_fault}, {31'b0, fault});
    check({name, " rdata"}, rsp_rdata, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add("lw_14",        0, 2'b10, 0, 32'h14,  32'h0,        0, 32'h00000005);
    add("sw_20",        1, 2'b10, 0, 32'h20,  32'h8899AABB, 0, 32'h0);
    add("sb_21",        1, 2'b00, 0, 32'h21,  32'hFFFFFF11, 0, 32'h0);
    add("lw_20",        0, 2'b10, 0, 32'h20,  32'h0,        0, 32'h889911BB);
    add("lb_23",        0, 2'b00, 0, 32'h23,  32'h0,        0, 32'hFFFFFF88);
    add("lbu_23",       0, 2'b00, 1, 32'h23,  32'h0,        0, 32'h00000088);
    add("lh_22",        0, 2'b01, 0, 32'h22,  32'h0,        0, 32'hFFFF8899);
    add("lhu_20",       0, 2'b01, 1, 32'h20,  32'h0,        0, 32'h000011BB);
    add("lb_20",        0, 2'b00, 0, 32'h20,  32'h0,        0, 32'hFFFFFFBB);
    add("lh_21_fault",  0, 2'b01, 0, 32'h21,  32'h0,        1, 32'h0);
    add("lw_22_fault",  0, 2'b10, 0, 32'h22,  32'h0,        1, 32'h0);
    add("sz3_fault",    0, 2'b11, 0, 32'h0,   32'h0,        1, 32'h0);
    add("lw_100_fault", 0, 2'b10, 0, 32'h100, 32'h0,        1, 32'h0);
    add("sh_21_fault",  1, 2'b01, 0, 32'h21,  32'hFFFF,     1, 32'h0);
    add("sw_100_fault", 1, 2'b10, 0, 32'h100, 32'hFFFFFFFF, 1, 32'h0);
    add("lw_20_again",  0, 2'b10, 0, 32'h20,  32'h0,        0, 32'h889911BB);
    add("lw_0",         0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h00000000);
    add("sh_26",        1, 2'b01, 0, 32'h26,  32'h1234CAFE, 0, 32'h0);
    add("lw_24",        0, 2'b10, 0, 32'h24,  32'h0,        0, 32'hCAFE0009);
    add("lh_26",        0, 2'b01, 0, 32'h26,  32'h0,        0, 32'hFFFFCAFE);
    add("lw_fc",        0, 2'b10, 1, 32'hFC,  32'h0,        0, 32'h0000003F);
    add("sb_ff",        1, 2'b00, 0, 32'hFF,  32'h0000007F, 0, 32'h0);
    add("lb_ff",        0, 2'b00, 0, 32'hFF,  32'h0,        0, 32'h0000007F);
    add("lw_fc_after",  0, 2'b10, 0, 32'hFC,  32'h0,        0, 32'h7F00003F);

    repeat (3) @(negedge clk);
    check_zero("reset");
    // A store held valid through INIT must be ignored.
    set_req(1, 2'b10, 0, 32'h14, 32'hFFFFFFFF);
    reset = 1;
    run_init("boot");

    foreach (vecs[i]) begin
      set_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      req_valid = 0;
      check({vecs[i].name, " valid"}, {31'b0, rsp_valid}, 1);
      check({vecs[i].name, " fault"}, {31'b0, rsp_fault}, {31'b0, vecs[i].fault});
      check({vecs[i].name, " rdata"}, rsp_rdata, vecs[i].rdata);
    end
    @(negedge clk);
    check("idle valid", {31'b0, rsp_valid}, 0);
    check("idle rdata hold", rsp_rdata, 32'h7F00003F);

    // Store then load of the same word on consecutive cycles.
    set_req(1, 2'b10, 0, 32'h30, 32'hDEADBEEF);
    @(negedge clk);
    check("b2b store valid", {31'b0, rsp_valid}, 1);
    check("b2b store rdata", rsp_rdata, 0);
    set_req(0, 2'b10, 0, 32'h30, 32'h0);
    @(negedge clk);
    req_valid = 0;
    check("b2b load valid", {31'b0, rsp_valid}, 1);
    check("b2b load rdata", rsp_rdata, 32'hDEADBEEF);
    check("b2b load fault", {31'b0, rsp_fault}, 0);
    @(negedge clk);
    check("b2b idle valid", {31'b0, rsp_valid}, 0);
    check("b2b idle hold", rsp_rdata, 32'hDEADBEEF);

    // Fault followed by idle: fault flag holds while rsp_valid is low.
    single("fault_hold", 0, 2'b11, 0, 32'h4, 32'h0, 1, 32'h0);
    @(negedge clk);
    check("fault hold flag", {31'b0, rsp_fault}, 1);
    check("fault hold valid", {31'b0, rsp_valid}, 0);

    // Reset mid-INIT, at cycle 20 of the sweep.
    reset = 0;
    @(negedge clk);
    reset = 1;
    repeat (20) @(posedge clk);
    #2 reset = 0;
    #1 check_zero("mid-init reset");
    repeat (2) @(negedge clk);
    reset = 1;
    run_init("reinit1");
    single("after reinit1 lw_30", 0, 2'b10, 0, 32'h30, 32'h0, 0, 32'h0000000C);

    // Reset mid-RUN just after a load is accepted: its response is dropped.
    set_req(0, 2'b10, 0, 32'h14, 32'h0);
    @(posedge clk);
    #1 check("pre-reset load valid", {31'b0, rsp_valid}, 1);
    check("pre-reset load rdata", rsp_rdata, 32'h5);
    #1 reset = 0;
    req_valid = 0;
    #1 check_zero("mid-run reset");
    @(negedge clk);
    check("reset held valid", {31'b0, rsp_valid}, 0);
    reset = 1;
    run_init("reinit2");
    single("after reinit2 lw_20", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h00000008);
    single("after reinit2 lw_fc", 0, 2'b10, 0, 32'hFC, 32'h0, 0, 32'h0000003F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
